// File: rtl/ps2_pkg.sv
// ps2_pkg: shared PS/2 set-2 transmit definitions.
//   PS2_SHIFT_L / PS2_BREAK : left-shift make code and break prefix
//   tx_state_e              : ascii2key_tx sequencing states
//   lut_res_t               : ASCII lookup result {hit, shift, code}
//   key_unsh / key_shft     : helpers building a lookup hit
// Configuration: BREAK_CODE_EN adds the break-sequence states.
package ps2_pkg;

  localparam logic [7:0] PS2_SHIFT_L = 8'h12;
  localparam logic [7:0] PS2_BREAK   = 8'hF0;

`ifdef BREAK_CODE_EN
  typedef enum logic [2:0] {
    StIdle, StShiftMk, StKeyMk, StKeyF0, StKeyBrk, StShiftF0, StShiftBrk
  } tx_state_e;
`else
  typedef enum logic [1:0] {
    StIdle, StShiftMk, StKeyMk
  } tx_state_e;
`endif

  typedef struct packed {
    logic       hit;
    logic       shift;
    logic [7:0] code;
  } lut_res_t;

  function automatic lut_res_t key_unsh(input logic [7:0] c);
    return '{hit: 1'b1, shift: 1'b0, code: c};
  endfunction

  function automatic lut_res_t key_shft(input logic [7:0] c);
    return '{hit: 1'b1, shift: 1'b1, code: c};
  endfunction

endpackage

// File: rtl/ascii2key_lut.sv
// ascii2key_lut: combinational ASCII -> PS/2 set-2 key lookup.
//   ascii_code : ASCII character
//   res        : {hit, shift, code}; hit=0 for characters with no key
module ascii2key_lut
  import ps2_pkg::*;
(
  input  logic [7:0] ascii_code,
  output lut_res_t   res
);

  // Letter keys indexed by alphabet position; shared by both cases.
  function automatic logic [7:0] letter_code(input logic [7:0] idx);
    logic [7:0] c;
    case (idx)
      8'd0:  c = 8'h1C; 8'd1:  c = 8'h32; 8'd2:  c = 8'h21; 8'd3:  c = 8'h23;
      8'd4:  c = 8'h24; 8'd5:  c = 8'h2B; 8'd6:  c = 8'h34; 8'd7:  c = 8'h33;
      8'd8:  c = 8'h43; 8'd9:  c = 8'h3B; 8'd10: c = 8'h42; 8'd11: c = 8'h4B;
      8'd12: c = 8'h3A; 8'd13: c = 8'h31; 8'd14: c = 8'h44; 8'd15: c = 8'h4D;
      8'd16: c = 8'h15; 8'd17: c = 8'h2D; 8'd18: c = 8'h1B; 8'd19: c = 8'h2C;
      8'd20: c = 8'h3C; 8'd21: c = 8'h2A; 8'd22: c = 8'h1D; 8'd23: c = 8'h22;
      8'd24: c = 8'h35; 8'd25: c = 8'h1A;
      default: c = 8'h00;
    endcase
    return c;
  endfunction

  always_comb begin
    res = '0;
    if (ascii_code inside {[8'h61:8'h7A]}) begin
      res = key_unsh(letter_code(ascii_code - 8'h61));
    end else if (ascii_code inside {[8'h41:8'h5A]}) begin
      res = key_shft(letter_code(ascii_code - 8'h41));
    end else begin
      case (ascii_code)
        8'h08: res = key_unsh(8'h66);  8'h09: res = key_unsh(8'h0D);
        8'h0D: res = key_unsh(8'h5A);  8'h1B: res = key_unsh(8'h76);
        8'h20: res = key_unsh(8'h29);  8'h21: res = key_shft(8'h16);
        8'h22: res = key_shft(8'h52);  8'h23: res = key_shft(8'h26);
        8'h24: res = key_shft(8'h25);  8'h25: res = key_shft(8'h2E);
        8'h26: res = key_shft(8'h3D);  8'h27: res = key_unsh(8'h52);
        8'h28: res = key_shft(8'h46);  8'h29: res = key_shft(8'h45);
        8'h2A: res = key_shft(8'h3E);  8'h2B: res = key_shft(8'h55);
        8'h2C: res = key_unsh(8'h41);  8'h2D: res = key_unsh(8'h4E);
        8'h2E: res = key_unsh(8'h49);  8'h2F: res = key_unsh(8'h4A);
        8'h30: res = key_unsh(8'h45);  8'h31: res = key_unsh(8'h16);
        8'h32: res = key_unsh(8'h1E);  8'h33: res = key_unsh(8'h26);
        8'h34: res = key_unsh(8'h25);  8'h35: res = key_unsh(8'h2E);
        8'h36: res = key_unsh(8'h36);  8'h37: res = key_unsh(8'h3D);
        8'h38: res = key_unsh(8'h3E);  8'h39: res = key_unsh(8'h46);
        8'h3A: res = key_shft(8'h4C);  8'h3B: res = key_unsh(8'h4C);
        8'h3C: res = key_shft(8'h41);  8'h3D: res = key_unsh(8'h55);
        8'h3E: res = key_shft(8'h49);  8'h3F: res = key_shft(8'h4A);
        8'h40: res = key_shft(8'h1E);  8'h5B: res = key_unsh(8'h54);
        8'h5C: res = key_unsh(8'h5D);  8'h5D: res = key_unsh(8'h5B);
        8'h5E: res = key_shft(8'h36);  8'h5F: res = key_shft(8'h4E);
        8'h60: res = key_unsh(8'h0E);  8'h7B: res = key_shft(8'h54);
        8'h7C: res = key_shft(8'h5D);  8'h7D: res = key_shft(8'h5B);
        8'h7E: res = key_shft(8'h0E);
        default: res = '0;
      endcase
    end
  end

endmodule

// File: rtl/ascii2key_tx.sv
// ascii2key_tx: one ASCII character in, PS/2 set-2 keystroke bytes out.
//   clk, reset_n          : clock, asynchronous active-low reset
//   ascii_valid/ready     : character input handshake; ascii_code is the character
//   byte_valid/ready      : scan byte output handshake; scan_byte is the byte
//   unmapped              : one-cycle pulse when an accepted character has no key
// Configuration: BREAK_CODE_EN emits make+break sequences; otherwise make codes only.
module ascii2key_tx
  import ps2_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       ascii_valid,
  input  logic [7:0] ascii_code,
  output logic       ascii_ready,
  output logic       byte_valid,
  output logic [7:0] scan_byte,
  input  logic       byte_ready,
  output logic       unmapped
);

  lut_res_t   lut;
  tx_state_e  state;
  logic [7:0] code_q;
  logic       hs;
`ifdef BREAK_CODE_EN
  logic       shift_q;
`endif

  assign hs = byte_valid & byte_ready;

  ascii2key_lut u_lut (
    .ascii_code (ascii_code),
    .res        (lut)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= StIdle;
      ascii_ready <= 1'b0;
      byte_valid  <= 1'b0;
      scan_byte   <= 8'h00;
      unmapped    <= 1'b0;
      code_q      <= 8'h00;
`ifdef BREAK_CODE_EN
      shift_q     <= 1'b0;
`endif
    end else begin
      unmapped <= 1'b0;
      unique case (state)
        StIdle: begin
          ascii_ready <= 1'b1;
          if (ascii_valid && ascii_ready) begin
            code_q <= lut.code;
`ifdef BREAK_CODE_EN
            shift_q <= lut.shift;
`endif
            if (!lut.hit) begin
              unmapped <= 1'b1;
            end else begin
              ascii_ready <= 1'b0;
              byte_valid  <= 1'b1;
              if (lut.shift) begin
                state     <= StShiftMk;
                scan_byte <= PS2_SHIFT_L;
              end else begin
                state     <= StKeyMk;
                scan_byte <= lut.code;
              end
            end
          end
        end
        StShiftMk: if (hs) begin
          state     <= StKeyMk;
          scan_byte <= code_q;
        end
`ifdef BREAK_CODE_EN
        StKeyMk: if (hs) begin
          state     <= StKeyF0;
          scan_byte <= PS2_BREAK;
        end
        StKeyF0: if (hs) begin
          state     <= StKeyBrk;
          scan_byte <= code_q;
        end
        StKeyBrk: if (hs) begin
          if (shift_q) begin
            state     <= StShiftF0;
            scan_byte <= PS2_BREAK;
          end else begin
            state       <= StIdle;
            byte_valid  <= 1'b0;
            ascii_ready <= 1'b1;
          end
        end
        StShiftF0: if (hs) begin
          state     <= StShiftBrk;
          scan_byte <= PS2_SHIFT_L;
        end
        StShiftBrk: if (hs) begin
          state       <= StIdle;
          byte_valid  <= 1'b0;
          ascii_ready <= 1'b1;
        end
`else
        StKeyMk: if (hs) begin
          state       <= StIdle;
          byte_valid  <= 1'b0;
          ascii_ready <= 1'b1;
        end
`endif
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_ascii2key_tx.sv
// tb_ascii2key_tx: self-checking bench for ascii2key_tx. A keyboard-layout model
// predicts every output each cycle; directed characters are also checked against
// hand-written byte lists. Expectations follow BREAK_CODE_EN when it is defined.
module tb_ascii2key_tx;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       ascii_valid = 1'b0;
  logic [7:0] ascii_code = 8'h00;
  logic       byte_ready = 1'b1;
  logic       ascii_ready, byte_valid, unmapped;
  logic [7:0] scan_byte;

  ascii2key_tx dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .ascii_valid (ascii_valid),
    .ascii_code  (ascii_code),
    .ascii_ready (ascii_ready),
    .byte_valid  (byte_valid),
    .scan_byte   (scan_byte),
    .byte_ready  (byte_ready),
    .unmapped    (unmapped)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Keyboard rows: unshifted and shifted legends share a key code per position.
  string      unsh_row = "1234567890-=qwertyuiop[]asdfghjkl;zxcvbnm,./";
  string      shft_row = "!@#$%^&*()_+QWERTYUIOP{}ASDFGHJKL:ZXCVBNM<>?";
  logic [7:0] key_code [44] = '{
    8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46, 8'h45, 8'h4E, 8'h55,
    8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C, 8'h35, 8'h3C, 8'h43, 8'h44, 8'h4D, 8'h54, 8'h5B,
    8'h1C, 8'h1B, 8'h23, 8'h2B, 8'h34, 8'h33, 8'h3B, 8'h42, 8'h4B, 8'h4C,
    8'h1A, 8'h22, 8'h21, 8'h2A, 8'h32, 8'h31, 8'h3A, 8'h41, 8'h49, 8'h4A
  };

  function automatic void model_lookup(input logic [7:0] c, output bit hit, output bit sh,
                                       output logic [7:0] k);
    hit = 0; sh = 0; k = 8'h00;
    for (int i = 0; i < 44; i++) begin
      if (c == unsh_row[i]) begin hit = 1; k = key_code[i]; end
      if (c == shft_row[i]) begin hit = 1; sh = 1; k = key_code[i]; end
    end
    case (c)
      8'h20: begin hit = 1; k = 8'h29; end
      8'h0D: begin hit = 1; k = 8'h5A; end
      8'h08: begin hit = 1; k = 8'h66; end
      8'h09: begin hit = 1; k = 8'h0D; end
      8'h1B: begin hit = 1; k = 8'h76; end
      8'h60: begin hit = 1; k = 8'h0E; end
      8'h7E: begin hit = 1; sh = 1; k = 8'h0E; end
      8'h5C: begin hit = 1; k = 8'h5D; end
      8'h7C: begin hit = 1; sh = 1; k = 8'h5D; end
      8'h27: begin hit = 1; k = 8'h52; end
      8'h22: begin hit = 1; sh = 1; k = 8'h52; end
      default: ;
    endcase
  endfunction

  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  bit         exp_unm = 0;
  bit         live;

  // Block is live from the first clock edge seen out of reset.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) live <= 1'b0;
    else          live <= 1'b1;
  end

  // Compare outputs every cycle, then advance the model for the coming edge.
  always @(negedge clk) begin
    bit hit, sh;
    logic [7:0] k;
    if (!reset_n) begin
      exp_q.delete();
      exp_unm = 0;
      check("rst_ascii_ready", ascii_ready, 0);
      check("rst_byte_valid", byte_valid, 0);
      check("rst_scan_byte", scan_byte, 0);
      check("rst_unmapped", unmapped, 0);
    end else begin
      check("byte_valid", byte_valid, exp_q.size() != 0);
      check("ascii_ready", ascii_ready, live && exp_q.size() == 0);
      check("unmapped", unmapped, exp_unm);
      if (exp_q.size() != 0) check("scan_byte", scan_byte, exp_q[0]);
      exp_unm = 0;
      if (byte_valid && byte_ready) got_q.push_back(scan_byte);
      if (exp_q.size() != 0) begin
        if (byte_ready) void'(exp_q.pop_front());
      end else if (live && ascii_valid) begin
        model_lookup(ascii_code, hit, sh, k);
        if (!hit) begin
          exp_unm = 1;
        end else begin
          if (sh) exp_q.push_back(8'h12);
          exp_q.push_back(k);
`ifdef BREAK_CODE_EN
          exp_q.push_back(8'hF0);
          exp_q.push_back(k);
          if (sh) begin
            exp_q.push_back(8'hF0);
            exp_q.push_back(8'h12);
          end
`endif
        end
      end
    end
  end

  task automatic wait_bytes(input int n);
    int cyc = 0;
    while (got_q.size() < n && cyc < 40) begin
      @(posedge clk);
      cyc++;
    end
  endtask

  task automatic compare_got(input string name, input int n, input logic [7:0] e [6]);
    repeat (3) @(posedge clk);
    check({name, "_count"}, got_q.size(), n);
    for (int i = 0; i < n; i++) begin
      if (i < got_q.size()) check({name, "_byte"}, got_q[i], e[i]);
    end
  endtask

  task automatic send(input string name, input logic [7:0] c, input int n,
                      input logic [7:0] e0, input logic [7:0] e1, input logic [7:0] e2,
                      input logic [7:0] e3, input logic [7:0] e4, input logic [7:0] e5);
    logic [7:0] e [6];
    e = '{e0, e1, e2, e3, e4, e5};
    got_q.delete();
    @(posedge clk); #1 ascii_valid = 1'b1; ascii_code = c;
    @(posedge clk); #1 ascii_valid = 1'b0; ascii_code = 8'h00;
    wait_bytes(n);
    compare_got(name, n, e);
  endtask

  initial begin
    logic [7:0] e [6];
    #3;
    check("reset_ascii_ready", ascii_ready, 0);
    check("reset_byte_valid", byte_valid, 0);
    check("reset_scan_byte", scan_byte, 0);
    @(posedge clk); #1 reset_n = 1'b1;
    check("ready_before_edge", ascii_ready, 0);
    @(posedge clk); #1;
    check("ready_after_edge", ascii_ready, 1);

`ifdef BREAK_CODE_EN
    send("a", 8'h61, 3, 8'h1C, 8'hF0, 8'h1C, 8'h00, 8'h00, 8'h00);
    send("A", 8'h41, 6, 8'h12, 8'h1C, 8'hF0, 8'h1C, 8'hF0, 8'h12);
    send("lbrace", 8'h7B, 6, 8'h12, 8'h54, 8'hF0, 8'h54, 8'hF0, 8'h12);
    send("esc", 8'h1B, 3, 8'h76, 8'hF0, 8'h76, 8'h00, 8'h00, 8'h00);
    send("nine", 8'h39, 3, 8'h46, 8'hF0, 8'h46, 8'h00, 8'h00, 8'h00);
`else
    send("a", 8'h61, 1, 8'h1C, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    send("A", 8'h41, 2, 8'h12, 8'h1C, 8'h00, 8'h00, 8'h00, 8'h00);
    send("lbrace", 8'h7B, 2, 8'h12, 8'h54, 8'h00, 8'h00, 8'h00, 8'h00);
    send("esc", 8'h1B, 1, 8'h76, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    send("nine", 8'h39, 1, 8'h46, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
`endif

    // Stall on the second byte of '!', with a stray character offered meanwhile.
    got_q.delete();
    @(posedge clk); #1 ascii_valid = 1'b1; ascii_code = 8'h21;
    @(posedge clk); #1 ascii_valid = 1'b0;
    @(posedge clk); #1 byte_ready = 1'b0; ascii_valid = 1'b1; ascii_code = 8'h62;
    @(negedge clk);
    check("stall_byte", scan_byte, 8'h16);
    check("stall_valid", byte_valid, 1);
    @(posedge clk); #1 ascii_valid = 1'b0;
    repeat (4) begin
      @(negedge clk);
      check("stall_byte", scan_byte, 8'h16);
      check("stall_valid", byte_valid, 1);
    end
    @(posedge clk); #1 byte_ready = 1'b1;
`ifdef BREAK_CODE_EN
    wait_bytes(6);
    e = '{8'h12, 8'h16, 8'hF0, 8'h16, 8'hF0, 8'h12};
    compare_got("bang", 6, e);
`else
    wait_bytes(2);
    e = '{8'h12, 8'h16, 8'h00, 8'h00, 8'h00, 8'h00};
    compare_got("bang", 2, e);
`endif

    // Unmapped characters back to back.
    @(posedge clk); #1 ascii_valid = 1'b1; ascii_code = 8'h7F;
    @(posedge clk); #1 ascii_code = 8'h80;
    check("unmapped_7f", unmapped, 1);
    check("unmapped_7f_ready", ascii_ready, 1);
    @(posedge clk); #1 ascii_valid = 1'b0;
    check("unmapped_80", unmapped, 1);
    check("unmapped_80_valid", byte_valid, 0);
    @(posedge clk); #1;
    check("unmapped_clear", unmapped, 0);

    // Reset after two handshakes of 'Z'.
    got_q.delete();
    @(posedge clk); #1 ascii_valid = 1'b1; ascii_code = 8'h5A;
    @(posedge clk); #1 ascii_valid = 1'b0;
    wait_bytes(2);
    check("z_two_bytes", got_q.size() >= 2, 1);
    #2 reset_n = 1'b0;
    #1;
    check("abort_byte_valid", byte_valid, 0);
    check("abort_ascii_ready", ascii_ready, 0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    @(posedge clk); #1;
`ifdef BREAK_CODE_EN
    send("zero", 8'h30, 3, 8'h45, 8'hF0, 8'h45, 8'h00, 8'h00, 8'h00);
`else
    send("zero", 8'h30, 1, 8'h45, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
`endif

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
